// File: rtl/vscale_dmem_bridge_pkg.sv
// vscale_dmem_bridge_pkg: funct3 size codes, bridge state encoding and access-legality helpers
package vscale_dmem_bridge_pkg;
  localparam logic [2:0] SZ_B  = 3'd0;
  localparam logic [2:0] SZ_H  = 3'd1;
  localparam logic [2:0] SZ_W  = 3'd2;
  localparam logic [2:0] SZ_BU = 3'd4;
  localparam logic [2:0] SZ_HU = 3'd5;
  localparam int DMEM_STATE_WIDTH = 2;
  typedef enum logic [DMEM_STATE_WIDTH-1:0] {ST_IDLE, ST_ISSUE, ST_RESP, ST_FAULT} state_t;
  function automatic logic size_legal(input logic [2:0] s);
    return s == SZ_B || s == SZ_H || s == SZ_W || s == SZ_BU || s == SZ_HU;
  endfunction
  function automatic logic misaligned(input logic [2:0] s, input logic [1:0] off);
    return (s[1:0] == 2'd1 && off[0]) || (s[1:0] == 2'd2 && off != 2'd0);
  endfunction
endpackage

// File: rtl/vscale_dmem_lane.sv
// vscale_dmem_lane: store byte-lane steering and load extraction with sign/zero extension
module vscale_dmem_lane
  import vscale_dmem_bridge_pkg::*;
(
  input  logic [2:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);
  logic [31:0] w_shift;
  always_comb begin
    w_shift = i_rdata >> {i_off, 3'b000};
    o_wstrb = i_size[1:0] == 2'd0 ? 4'b0001 << i_off : i_size[1:0] == 2'd1 ? 4'b0011 << i_off : 4'hF;
    o_wdata = i_size[1:0] == 2'd0 ? {4{i_wdata[7:0]}} : i_size[1:0] == 2'd1 ? {2{i_wdata[15:0]}} : i_wdata;
    o_rdata = i_size == SZ_B  ? {{24{w_shift[7]}}, w_shift[7:0]} :
              i_size == SZ_BU ? {24'h0, w_shift[7:0]} :
              i_size == SZ_H  ? {{16{w_shift[15]}}, w_shift[15:0]} :
              i_size == SZ_HU ? {16'h0, w_shift[15:0]} : w_shift;
  end
endmodule

// File: rtl/vscale_dmem_bridge.sv
// vscale_dmem_bridge: core dmem port to valid/ready memory bus; VSCALE_DMEM_TIMEOUT_EN adds a response watchdog
module vscale_dmem_bridge
  import vscale_dmem_bridge_pkg::*;
#(
  parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
  parameter logic [31:0] MEM_BYTES = 32'h0001_0000
`ifdef VSCALE_DMEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dmem_en,
  input  logic        dmem_wen,
  input  logic [2:0]  dmem_size,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata_delayed,
  output logic [31:0] dmem_rdata,
  output logic        dmem_wait,
  output logic        dmem_badmem_e,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_addr,
  output logic [3:0]  mem_req_wstrb,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata
);
  state_t      r_state, w_next, w_after;
  logic        r_wen, r_first;
  logic [2:0]  r_size;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic        w_capture, w_legal, w_done, w_tmo_hit;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata, w_load;
  vscale_dmem_lane u_lane (
    .i_size  (r_size),
    .i_off   (r_addr[1:0]),
    .i_wdata (dmem_wdata_delayed),
    .i_rdata (mem_resp_rdata),
    .o_wstrb (w_wstrb),
    .o_wdata (w_wdata),
    .o_rdata (w_load)
  );
  assign w_legal = size_legal(dmem_size) && !misaligned(dmem_size, dmem_addr[1:0]) &&
                   (dmem_addr - MEM_BASE) < MEM_BYTES;
  assign w_done        = r_state == ST_RESP && mem_resp_valid;
  assign dmem_wait     = r_state == ST_ISSUE || (r_state == ST_RESP && !mem_resp_valid);
  assign dmem_badmem_e = r_state == ST_FAULT;
  assign mem_req_valid = r_state == ST_ISSUE;
  assign mem_req_wen   = r_wen;
  assign mem_req_addr  = {r_addr[31:2], 2'b00};
  assign mem_req_wstrb = r_wen ? w_wstrb : 4'h0;
  // store data is only valid on the bus in the first ISSUE cycle; later cycles replay the register
  assign mem_req_wdata = r_first ? w_wdata : r_wdata;
  assign dmem_rdata    = (w_done && !r_wen) ? w_load : r_rdata;
  always_comb begin
    w_capture = dmem_en && !dmem_wait;
    w_after   = w_capture ? (w_legal ? ST_ISSUE : ST_FAULT) : ST_IDLE;
    w_next    = w_after;
    if (r_state == ST_ISSUE) w_next = mem_req_ready ? ST_RESP : ST_ISSUE;
    else if (r_state == ST_RESP && !mem_resp_valid) w_next = w_tmo_hit ? ST_FAULT : ST_RESP;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_first <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      r_state <= w_next;
      r_first <= w_capture && w_legal;
      if (r_first) r_wdata <= w_wdata;
      if (w_capture) begin
        r_wen  <= dmem_wen;
        r_size <= dmem_size;
        r_addr <= dmem_addr;
      end
      if (w_done && !r_wen) r_rdata <= w_load;
    end
  end
`ifdef VSCALE_DMEM_TIMEOUT_EN
  logic [15:0] r_tmo;
  assign w_tmo_hit = r_state == ST_RESP && r_tmo == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (!reset_n) r_tmo <= 16'h0;
    else r_tmo <= r_state == ST_RESP ? r_tmo + 16'h1 : 16'h0;
  end
`else
  assign w_tmo_hit = 1'b0;
`endif
endmodule

// File: tb/tb_vscale_dmem_bridge.sv
// tb_vscale_dmem_bridge: scoreboard bench for vscale_dmem_bridge
module tb_vscale_dmem_bridge;
  logic        clk = 1'b0;
  logic        reset_n, dmem_en, dmem_wen, dmem_wait, dmem_badmem_e;
  logic [2:0]  dmem_size;
  logic [31:0] dmem_addr, dmem_wdata_delayed, dmem_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;
  logic [3:0]  mem_req_wstrb;
  int vec = 0, errs = 0;
  logic [31:0] last_rd = 32'h0;
  typedef struct {logic wen; logic [31:0] addr; logic [3:0] strb; logic [31:0] wdata;} req_t;
  req_t req_q[$];
  logic [31:0] rd_q[$];

  vscale_dmem_bridge dut (
    .clk(clk), .reset_n(reset_n), .dmem_en(dmem_en), .dmem_wen(dmem_wen),
    .dmem_size(dmem_size), .dmem_addr(dmem_addr), .dmem_wdata_delayed(dmem_wdata_delayed),
    .dmem_rdata(dmem_rdata), .dmem_wait(dmem_wait), .dmem_badmem_e(dmem_badmem_e),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr), .mem_req_wstrb(mem_req_wstrb), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (reset_n) assert (!(mem_req_valid && mem_req_ready && mem_resp_valid))
      else $error("response in the acceptance cycle");

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_req(input int k);
    req_t e;
    e = req_q[0];
    vec++;
    if (mem_req_valid !== 1'b1 || dmem_wait !== 1'b1 || mem_req_wen !== e.wen || mem_req_addr !== e.addr ||
        mem_req_wstrb !== e.strb || (e.wen && mem_req_wdata !== e.wdata)) begin
      errs++;
      $display("FAIL req_fields k=%0d: got v=%b wait=%b wen=%b a=%h s=%b d=%h, expected v=1 wait=1 wen=%b a=%h s=%b d=%h",
               k, mem_req_valid, dmem_wait, mem_req_wen, mem_req_addr, mem_req_wstrb, mem_req_wdata,
               e.wen, e.addr, e.strb, e.wdata);
    end
  endtask

  task automatic access(input logic wen, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wd, input int rdy_dly, input int resp_dly,
                        input logic [31:0] word, input logic [3:0] strb,
                        input logic [31:0] exp_wd, input logic [31:0] exp_rd);
    int k, waits, accs;
    logic [31:0] r;
    req_q.push_back('{wen, {addr[31:2], 2'b00}, strb, exp_wd});
    if (!wen) rd_q.push_back(exp_rd);
    dmem_en = 1'b1; dmem_wen = wen; dmem_size = size; dmem_addr = addr;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    tick();
    dmem_en = 1'b0; dmem_wdata_delayed = wd;
    k = 0; waits = 0; accs = 0;
    while (accs == 0 && k < 20) begin
      mem_req_ready = k >= rdy_dly;
      @(negedge clk);
      check_req(k);
      if (mem_req_valid && mem_req_ready) accs++;
      if (dmem_wait) waits++;
      k++;
      tick();
      dmem_wdata_delayed = ~wd;
    end
    vec++;
    if (accs != 1) begin
      errs++;
      $display("FAIL accept: got %0d acceptances, expected 1", accs);
    end
    void'(req_q.pop_front());
    mem_req_ready = 1'b0;
    for (int j = 0; j < resp_dly; j++) begin
      @(negedge clk);
      if (dmem_wait) waits++;
      vec++;
      if (mem_req_valid !== 1'b0) begin
        errs++;
        $display("FAIL resp_wait_valid: got valid=%b, expected 0", mem_req_valid);
      end
      tick();
    end
    mem_resp_valid = 1'b1; mem_resp_rdata = word;
    @(negedge clk);
    vec++;
    if (dmem_wait !== 1'b0 || waits != rdy_dly + 1 + resp_dly) begin
      errs++;
      $display("FAIL wait_profile: got wait=%b cycles=%0d, expected wait=0 cycles=%0d",
               dmem_wait, waits, rdy_dly + 1 + resp_dly);
    end
    if (!wen) begin
      r = rd_q.pop_front();
      last_rd = r;
      vec++;
      if (dmem_rdata !== r) begin
        errs++;
        $display("FAIL load_data a=%h sz=%0d: got %h, expected %h", addr, size, dmem_rdata, r);
      end
    end
    tick();
    mem_resp_valid = 1'b0; mem_resp_rdata = $urandom;
    @(negedge clk);
    vec++;
    if (dmem_rdata !== last_rd || dmem_wait !== 1'b0 || mem_req_valid !== 1'b0) begin
      errs++;
      $display("FAIL post_access: got rdata=%h wait=%b v=%b, expected rdata=%h wait=0 v=0",
               dmem_rdata, dmem_wait, mem_req_valid, last_rd);
    end
    tick();
  endtask

  task automatic fault(input logic wen, input logic [2:0] size, input logic [31:0] addr);
    mem_req_ready = 1'b1;
    dmem_en = 1'b1; dmem_wen = wen; dmem_size = size; dmem_addr = addr;
    tick();
    dmem_en = 1'b0;
    @(negedge clk);
    vec++;
    if (dmem_badmem_e !== 1'b1 || dmem_wait !== 1'b0 || mem_req_valid !== 1'b0) begin
      errs++;
      $display("FAIL fault a=%h sz=%0d: got bad=%b wait=%b v=%b, expected bad=1 wait=0 v=0",
               addr, size, dmem_badmem_e, dmem_wait, mem_req_valid);
    end
    tick();
    @(negedge clk);
    vec++;
    if (dmem_badmem_e !== 1'b0 || mem_req_valid !== 1'b0) begin
      errs++;
      $display("FAIL fault_end a=%h: got bad=%b v=%b, expected bad=0 v=0", addr, dmem_badmem_e, mem_req_valid);
    end
    tick();
    mem_req_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; dmem_en = 1'b0; dmem_wen = 1'b0; dmem_size = 3'd0; dmem_addr = 32'h0;
    dmem_wdata_delayed = 32'h0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 32'h0;
    repeat (3) tick();
    @(negedge clk);
    vec++;
    if (dmem_wait !== 1'b0 || dmem_badmem_e !== 1'b0 || mem_req_valid !== 1'b0 || dmem_rdata !== 32'h0) begin
      errs++;
      $display("FAIL reset: got wait=%b bad=%b v=%b rdata=%h, expected 0 0 0 00000000",
               dmem_wait, dmem_badmem_e, mem_req_valid, dmem_rdata);
    end
    tick();
    reset_n = 1'b1;
    tick();
    last_rd = 32'h0;
  endtask

  task automatic test_load_latency;
    access(1'b0, 3'd2, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF, 4'h0, 32'h0, 32'hDEADBEEF);
    access(1'b0, 3'd2, 32'h0000_FFFC, 32'h0, 0, 0, 32'h0BAD_F00D, 4'h0, 32'h0, 32'h0BAD_F00D);
  endtask

  task automatic test_load_ext;
    access(1'b0, 3'd0, 32'h103, 32'h0, 0, 0, 32'h80FF_1234, 4'h0, 32'h0, 32'hFFFF_FF80);
    access(1'b0, 3'd4, 32'h103, 32'h0, 0, 0, 32'h80FF_1234, 4'h0, 32'h0, 32'h0000_0080);
    access(1'b0, 3'd1, 32'h100, 32'h0, 0, 0, 32'h80FF_1234, 4'h0, 32'h0, 32'h0000_1234);
    access(1'b0, 3'd1, 32'h102, 32'h0, 0, 0, 32'h80FF_1234, 4'h0, 32'h0, 32'hFFFF_80FF);
    access(1'b0, 3'd5, 32'h102, 32'h0, 0, 0, 32'h80FF_1234, 4'h0, 32'h0, 32'h0000_80FF);
    access(1'b0, 3'd0, 32'h101, 32'h0, 0, 0, 32'h80FF_1234, 4'h0, 32'h0, 32'h0000_0012);
  endtask

  task automatic test_store_lanes;
    access(1'b1, 3'd1, 32'h102, 32'h0000_ABCD, 0, 0, 32'h0, 4'b1100, 32'hABCD_ABCD, 32'h0);
    access(1'b1, 3'd0, 32'h101, 32'h1234_56EF, 0, 1, 32'h0, 4'b0010, 32'hEFEF_EFEF, 32'h0);
    access(1'b1, 3'd2, 32'h104, 32'hCAFE_F00D, 0, 0, 32'h0, 4'hF, 32'hCAFE_F00D, 32'h0);
  endtask

  task automatic test_ready_stall;
    access(1'b1, 3'd2, 32'h200, 32'h5A5A_1234, 3, 0, 32'h0, 4'hF, 32'h5A5A_1234, 32'h0);
    access(1'b0, 3'd1, 32'h206, 32'h0, 3, 2, 32'h7654_3210, 4'h0, 32'h0, 32'h0000_7654);
  endtask

  task automatic test_back_to_back;
    logic [31:0] r;
    req_q.push_back('{1'b0, 32'h104, 4'h0, 32'h0});
    rd_q.push_back(32'h1122_3344);
    mem_req_ready = 1'b1;
    dmem_en = 1'b1; dmem_wen = 1'b0; dmem_size = 3'd2; dmem_addr = 32'h104;
    tick();
    dmem_en = 1'b0;
    @(negedge clk);
    check_req(0);
    void'(req_q.pop_front());
    tick();
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1122_3344;
    dmem_en = 1'b1; dmem_size = 3'd5; dmem_addr = 32'h10A;
    req_q.push_back('{1'b0, 32'h108, 4'h0, 32'h0});
    rd_q.push_back(32'h0000_A5A5);
    @(negedge clk);
    r = rd_q.pop_front();
    vec++;
    if (dmem_wait !== 1'b0 || dmem_rdata !== r) begin
      errs++;
      $display("FAIL b2b_first: got wait=%b rdata=%h, expected wait=0 rdata=%h", dmem_wait, dmem_rdata, r);
    end
    tick();
    mem_resp_valid = 1'b0; dmem_en = 1'b0;
    @(negedge clk);
    check_req(1);
    void'(req_q.pop_front());
    tick();
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hA5A5_0000;
    @(negedge clk);
    r = rd_q.pop_front();
    last_rd = r;
    vec++;
    if (dmem_wait !== 1'b0 || dmem_rdata !== r) begin
      errs++;
      $display("FAIL b2b_second: got wait=%b rdata=%h, expected wait=0 rdata=%h", dmem_wait, dmem_rdata, r);
    end
    tick();
    mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
    tick();
  endtask

  task automatic test_faults;
    fault(1'b0, 3'd2, 32'h101);
    fault(1'b1, 3'd2, 32'h0001_0000);
    fault(1'b0, 3'd1, 32'h103);
    fault(1'b0, 3'd3, 32'h100);
    fault(1'b1, 3'd6, 32'h100);
    fault(1'b0, 3'd2, 32'hFFFF_FFFC);
  endtask

  task automatic test_stray_resp;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1357_9BDF;
    @(negedge clk);
    vec++;
    if (dmem_wait !== 1'b0 || dmem_rdata !== last_rd) begin
      errs++;
      $display("FAIL stray_resp: got wait=%b rdata=%h, expected wait=0 rdata=%h", dmem_wait, dmem_rdata, last_rd);
    end
    tick();
    mem_resp_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_resp;
    mem_req_ready = 1'b1;
    dmem_en = 1'b1; dmem_wen = 1'b0; dmem_size = 3'd2; dmem_addr = 32'h100;
    tick();
    dmem_en = 1'b0;
    tick();
    mem_req_ready = 1'b0;
    @(negedge clk);
    vec++;
    if (dmem_wait !== 1'b1) begin
      errs++;
      $display("FAIL mid_resp_wait: got %b, expected 1", dmem_wait);
    end
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = 32'hFFFF_FFFF;
    last_rd = 32'h0;
    @(negedge clk);
    vec++;
    if (dmem_wait !== 1'b0 || mem_req_valid !== 1'b0 || dmem_badmem_e !== 1'b0 || dmem_rdata !== 32'h0) begin
      errs++;
      $display("FAIL reset_mid_resp: got wait=%b v=%b bad=%b rdata=%h, expected 0 0 0 00000000",
               dmem_wait, mem_req_valid, dmem_badmem_e, dmem_rdata);
    end
    tick();
    mem_resp_valid = 1'b0;
    access(1'b0, 3'd2, 32'h300, 32'h0, 0, 0, 32'h2468_ACE0, 4'h0, 32'h0, 32'h2468_ACE0);
  endtask

`ifdef VSCALE_DMEM_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    bit seen;
    mem_req_ready = 1'b1;
    dmem_en = 1'b1; dmem_wen = 1'b0; dmem_size = 3'd2; dmem_addr = 32'h100;
    tick();
    dmem_en = 1'b0;
    tick();
    mem_req_ready = 1'b0;
    n = 0; seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (dmem_badmem_e) seen = 1;
      else if (dmem_wait) n++;
      if (!seen) tick();
    end
    vec++;
    if (!seen || n != 64 || dmem_wait !== 1'b0) begin
      errs++;
      $display("FAIL timeout: got seen=%0d wait_cycles=%0d wait=%b, expected seen=1 wait_cycles=64 wait=0",
               seen, n, dmem_wait);
    end
    tick();
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h7777_7777;
    @(negedge clk);
    vec++;
    if (dmem_wait !== 1'b0 || dmem_badmem_e !== 1'b0 || dmem_rdata !== last_rd) begin
      errs++;
      $display("FAIL late_resp: got wait=%b bad=%b rdata=%h, expected 0 0 %h",
               dmem_wait, dmem_badmem_e, dmem_rdata, last_rd);
    end
    tick();
    mem_resp_valid = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_load_latency();
    test_load_ext();
    test_store_lanes();
    test_ready_stall();
    test_back_to_back();
    test_faults();
    test_stray_resp();
    test_reset_mid_resp();
`ifdef VSCALE_DMEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
